stereo_frame_packer: RTL
========================

Name: stereo_frame_packer

Overview:
- Write-side producer for the stereo matcher's left/right frame-buffer BRAMs (48-bit words, 6 pixels per word).
- Accepts two independent 8-bit raster pixel streams (left/right camera) and packs each into 48-bit words in a per-side word FIFO.
- Issues lock-step writes to both BRAMs at a shared word address, then pulses new_frame_out to start the matcher.
- Sits between camera capture and the stereo matcher's new_frame_in / writing_image / external_*_addr inputs.

Parameters:
IMG_W, 240, pixels per row (x extent); must be a multiple of BLOCK_SIZE
IMG_H, 320, rows per frame (y extent)
BLOCK_SIZE, 6, pixels packed per BRAM word
FIFO_DEPTH, 4, words buffered per side; power of two, >=2

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous, active-high reset
left_pixel  in  8  left camera pixel
left_valid  in  1  left_pixel valid this cycle
left_sof  in  1  start of frame; qualified by left_valid, marks pixel (0,0)
right_pixel  in  8  right camera pixel
right_valid  in  1  right_pixel valid this cycle
right_sof  in  1  start of frame; qualified by right_valid
matcher_ready  in  1  level; high when the stereo engine is idle and its BRAMs may be overwritten
writing_image  out  1  BRAM write enable, common to both BRAMs
left_addr  out  $clog2(IMG_H*IMG_W/BLOCK_SIZE)  left BRAM word address (14 bits at defaults)
right_addr  out  same  right BRAM word address; always equals left_addr
left_din  out  48  packed left word
right_din  out  48  packed right word
new_frame_out  out  1  one-cycle pulse when a full frame pair is written
busy  out  1  high in any state other than IDLE
overflow  out  1  sticky; a word was pushed into a full FIFO
sync_error  out  1  sticky; sof seen mid-frame on either side

Behaviour:
- Reset: all outputs 0; state IDLE; FIFOs empty; all counters 0. Reset mid-frame discards all partial data immediately, with no write and no pulse.
- Word layout: first pixel of a group goes in [47:40], last in [7:0]. Word address = y*(IMG_W/BLOCK_SIZE) + x/BLOCK_SIZE, i.e. raster word order 0..12799 at defaults.

States:
- IDLE: when matcher_ready=1, go to ARM.
- ARM: each side arms independently on its first valid&sof. That pixel is packed as pixel 0. Valid pixels on a side before its sof are discarded. Go to CAPTURE once either side is armed.
- CAPTURE:
  - Each armed side counts accepted pixels up to IMG_W*IMG_H (76800).
  - Every BLOCK_SIZE-th pixel pushes the completed word into that side's FIFO one cycle later.
  - Pixels beyond 76800 on a side are ignored.
  - A valid&sof on an already-armed side is ignored and sets sync_error.
- Write rule (CAPTURE only): when both FIFOs are non-empty, pop both heads. Next cycle, writing_image=1, left_din/right_din = the popped heads, left_addr=right_addr=wr_count. wr_count then increments.
- Back-to-back writes are allowed every cycle. writing_image is 0 on any cycle without a write; din/addr hold their last values.
- Latency: 6th pixel accepted at cycle N -> word in FIFO at N+1 -> writing_image high at N+2 at the earliest, if the other side's word is already present.
- FIFO full:
  - A push and a pop in the same cycle on a full FIFO is legal, with no overflow.
  - A push to a full FIFO without a simultaneous pop sets overflow, flushes both FIFOs and returns to IDLE. No new_frame_out is pulsed and the frame is aborted.
- Frame completion: the write of the last word (addr = 12799) transitions to DONE. DONE asserts new_frame_out for exactly 1 cycle, then returns to IDLE.
- matcher_ready is sampled only in IDLE. Deassertion during ARM/CAPTURE has no effect.
- overflow and sync_error clear only on rst_in.

Test Plan:
- Clean frame: both sides stream 76800 pixels with pixel = (x+y)&8'hFF, sof on the first pixel, aligned -> exactly 12800 writes with addr 0..12799 in order. Word 0 on both sides = 48'h000102030405. new_frame_out pulses once, 1 cycle after the addr-12799 write.
- Skew: right stream lags left by 20 cycles, FIFO_DEPTH=4 -> no overflow, writes paired and in order, first write ≥2 cycles after the right's 6th pixel.
- Overflow: left streams continuously while right stalls for 40 cycles -> 5th unpaired left word sets overflow, FIFOs flushed, state IDLE, no new_frame_out, overflow stays 1.
- Pre-sof garbage and mid-frame sof: 10 valid pixels with sof=0 before sof are discarded, so word 0 starts at the sof pixel. A second sof at pixel 500 sets sync_error and the frame still completes normally.
- matcher_ready=0 with both streams active -> no writes, busy=0. Raise matcher_ready -> ARM, capture starts at the next sof.
- Async reset asserted mid-CAPTURE (wr_count=3000) -> all outputs 0 immediately, no further writes. The next frame restarts at addr 0.

Source files
------------

// File: rtl/stereo_frame_packer.sv
// Packs left/right camera pixel streams into BLOCK_SIZE-pixel words and
// writes both frame-buffer BRAMs in lock-step, then starts the matcher.
module stereo_frame_packer #(
    parameter int IMG_W      = 240,
    parameter int IMG_H      = 320,
    parameter int BLOCK_SIZE = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                        clk_in,
    input  logic                                        rst_in,
    input  logic [7:0]                                  left_pixel,
    input  logic                                        left_valid,
    input  logic                                        left_sof,
    input  logic [7:0]                                  right_pixel,
    input  logic                                        right_valid,
    input  logic                                        right_sof,
    input  logic                                        matcher_ready,
    output logic                                        writing_image,
    output logic [$clog2(IMG_H*IMG_W/BLOCK_SIZE)-1:0]   left_addr,
    output logic [$clog2(IMG_H*IMG_W/BLOCK_SIZE)-1:0]   right_addr,
    output logic [8*BLOCK_SIZE-1:0]                     left_din,
    output logic [8*BLOCK_SIZE-1:0]                     right_din,
    output logic                                        new_frame_out,
    output logic                                        busy,
    output logic                                        overflow,
    output logic                                        sync_error
);

    localparam int NW   = IMG_H * IMG_W / BLOCK_SIZE;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = $clog2(NW);
    localparam int PW   = $clog2(NPIX + 1);
    localparam int GW   = $clog2(BLOCK_SIZE);
    localparam int FW   = $clog2(FIFO_DEPTH);
    localparam int DW   = 8 * BLOCK_SIZE;

    localparam logic [AW-1:0] LAST_A = AW'(NW - 1);
    localparam logic [PW-1:0] NPIX_L = PW'(NPIX);
    localparam logic [GW-1:0] GLAST  = GW'(BLOCK_SIZE - 1);
    localparam logic [FW:0]   FULL   = (FW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

    state_t state_q, state_d;

    // Index 0 is the left side, index 1 the right side.
    logic [1:0][7:0]    pix;
    logic [1:0]         vld;
    logic [1:0]         sof;

    logic [1:0]          armed_q, armed_d;
    logic [1:0][PW-1:0]  pcnt_q, pcnt_d;
    logic [1:0][GW-1:0]  grp_q, grp_d;
    logic [1:0][DW-1:0]  sh_q, sh_d;
    logic [1:0][FW-1:0]  wp_q, wp_d;
    logic [1:0][FW-1:0]  rp_q, rp_d;
    logic [1:0][FW:0]    cnt_q, cnt_d;
    logic [DW-1:0]       mem_q [2][FIFO_DEPTH];

    logic [AW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] ldin_q, ldin_d;
    logic [DW-1:0] rdin_q, rdin_d;
    logic          wr_q, wr_d;
    logic          ovf_q, ovf_d;
    logic          serr_q, serr_d;

    logic              capt;
    logic              pop;
    logic              ovf_evt;
    logic [1:0]        acc;
    logic [1:0]        push;
    logic [1:0]        arm_now;
    logic [1:0][DW-1:0] head;

    assign pix = {right_pixel, left_pixel};
    assign vld = {right_valid, left_valid};
    assign sof = {right_sof, left_sof};

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        pcnt_d  = pcnt_q;
        grp_d   = grp_q;
        sh_d    = sh_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        ldin_d  = ldin_q;
        rdin_d  = rdin_q;
        wr_d    = 1'b0;
        ovf_d   = ovf_q;
        serr_d  = serr_q;
        acc     = '0;
        push    = '0;
        arm_now = '0;
        ovf_evt = 1'b0;
        head    = '0;

        capt = (state_q == ARM) || (state_q == CAPTURE);
        pop  = (state_q == CAPTURE) && (cnt_q[0] != '0) && (cnt_q[1] != '0);

        for (int s = 0; s < 2; s++) begin
            head[s] = mem_q[s][rp_q[s]];
            if (capt && vld[s] && sof[s] && armed_q[s])
                serr_d = 1'b1;
            arm_now[s] = capt && vld[s] && sof[s] && !armed_q[s];
            acc[s] = capt && vld[s] && (armed_q[s] || sof[s])
                     && (pcnt_q[s] < NPIX_L);
            if (acc[s]) begin
                armed_d[s] = 1'b1;
                pcnt_d[s]  = pcnt_q[s] + 1'b1;
                sh_d[s]    = {sh_q[s][DW-9:0], pix[s]};
                if (grp_q[s] == GLAST) begin
                    grp_d[s] = '0;
                    push[s]  = 1'b1;
                end else begin
                    grp_d[s] = grp_q[s] + 1'b1;
                end
            end
            if (push[s] && (cnt_q[s] == FULL) && !pop)
                ovf_evt = 1'b1;
            if (push[s])
                wp_d[s] = wp_q[s] + 1'b1;
            if (pop)
                rp_d[s] = rp_q[s] + 1'b1;
            cnt_d[s] = cnt_q[s] + {{FW{1'b0}}, push[s]}
                                - {{FW{1'b0}}, pop};
        end

        if (pop) begin
            wr_d   = 1'b1;
            addr_d = wcnt_q;
            ldin_d = head[0];
            rdin_d = head[1];
            wcnt_d = wcnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE:    if (matcher_ready) state_d = ARM;
            ARM:     if (|arm_now) state_d = CAPTURE;
            CAPTURE: if (wr_q && (addr_q == LAST_A)) state_d = DONE;
            DONE:    state_d = IDLE;
        endcase

        if (ovf_evt) begin
            ovf_d   = 1'b1;
            state_d = IDLE;
        end

        // Per-frame state is held clear while idle and dropped on abort.
        if ((state_q == IDLE) || ovf_evt) begin
            armed_d = '0;
            pcnt_d  = '0;
            grp_d   = '0;
            wp_d    = '0;
            rp_d    = '0;
            cnt_d   = '0;
            wcnt_d  = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            armed_q <= '0;
            pcnt_q  <= '0;
            grp_q   <= '0;
            sh_q    <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            ldin_q  <= '0;
            rdin_q  <= '0;
            wr_q    <= 1'b0;
            ovf_q   <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            pcnt_q  <= pcnt_d;
            grp_q   <= grp_d;
            sh_q    <= sh_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            ldin_q  <= ldin_d;
            rdin_q  <= rdin_d;
            wr_q    <= wr_d;
            ovf_q   <= ovf_d;
            serr_q  <= serr_d;
        end
    end

    always_ff @(posedge clk_in) begin
        for (int s = 0; s < 2; s++)
            if (push[s])
                mem_q[s][wp_q[s]] <= sh_d[s];
    end

    assign writing_image = wr_q;
    assign left_addr     = addr_q;
    assign right_addr    = addr_q;
    assign left_din      = ldin_q;
    assign right_din     = rdin_q;
    assign new_frame_out = (state_q == DONE);
    assign busy          = (state_q != IDLE);
    assign overflow      = ovf_q;
    assign sync_error    = serr_q;

endmodule
